// File: rtl/afe_pkg.sv
// Shared constants for the multi-channel AFE time-over-threshold block:
// register map, SPI frame layout and channel FSM state encoding.
package afe_pkg;

  localparam logic [6:0] ADDR_GPIO   = 7'h00;
  localparam logic [6:0] ADDR_HIT    = 7'h01;
  localparam logic [6:0] ADDR_OVF    = 7'h02;
  localparam logic [6:0] ADDR_BUSY   = 7'h03;
  localparam logic [6:0] ADDR_TOT_LO = 7'h10;
  localparam logic [6:0] ADDR_TOT_HI = 7'h20;
  localparam logic [6:0] ADDR_TOA_LO = 7'h30;
  localparam logic [6:0] ADDR_TOA_HI = 7'h40;

  localparam int CMD_WR_BIT = 7;
  localparam int FRAME_BITS = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } chan_state_t;

  function automatic logic is_busy(input chan_state_t s);
    return (s == ST_ARMED) || (s == ST_COUNT);
  endfunction

endpackage

// File: rtl/afe_tot_channel.sv
// One comparator channel: injection-gated TOT counter with hit/overflow flags.
// Optional TOA counter (cycles spent armed) is built when AFE_TOA_EN is defined.
module afe_tot_channel
  import afe_pkg::*;
#(
  parameter int TOT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 inj,
  input  logic                 inj_rise,
  input  logic                 inj_fall,
  input  logic                 comp,
  output chan_state_t          state,
  output logic                 hit,
  output logic                 ovf,
  output logic [TOT_WIDTH-1:0] tot
`ifdef AFE_TOA_EN
  ,
  output logic [TOT_WIDTH-1:0] toa
`endif
);

  localparam logic [TOT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [TOT_WIDTH-1:0] CNT_ONE = TOT_WIDTH'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      tot   <= '0;
      hit   <= 1'b0;
      ovf   <= 1'b0;
`ifdef AFE_TOA_EN
      toa   <= '0;
`endif
    end else if (inj_rise) begin
      // A new injection always re-arms, whatever the channel was doing.
      state <= ST_ARMED;
      tot   <= '0;
      hit   <= 1'b0;
      ovf   <= 1'b0;
`ifdef AFE_TOA_EN
      toa   <= '0;
`endif
    end else begin
      case (state)
        ST_ARMED: begin
          if (comp) begin
            state <= ST_COUNT;
            tot   <= CNT_ONE;
            hit   <= 1'b1;
          end else if (!inj) begin
            state <= ST_DONE;
            tot   <= '0;
            hit   <= 1'b0;
          end
        end
        ST_COUNT: begin
          if (comp && inj) begin
            if (tot == CNT_MAX) ovf <= 1'b1;
            else                tot <= tot + CNT_ONE;
          end else begin
            state <= ST_DONE;
          end
        end
        default: ;
      endcase
`ifdef AFE_TOA_EN
      if (state == ST_ARMED && toa != CNT_MAX) toa <= toa + CNT_ONE;
`endif
      // Hit is only meaningful while the injection window is open.
      if (inj_fall) hit <= 1'b0;
    end
  end

endmodule

// File: rtl/afe_tot_multi.sv
// Multi-channel AFE TOT block: input synchronisers, per-channel TOT engines and
// a CLK-domain SPI register slave. TOA registers exist only with AFE_TOA_EN.
module afe_tot_multi
  import afe_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int TOT_WIDTH   = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            INJ_IN,
  input  logic [N_CH-1:0] COMP,
  output logic [N_CH-1:0] HIT,
  output logic            INJ_OUT,
  input  logic            SCLK,
  input  logic            CS_B,
  input  logic            MOSI,
  output logic            MISO,
  output logic [7:0]      GPIO,
  output logic            LED
);

  localparam int SW = N_CH + 4;
  // Chip select idles high so reset never looks like the start of a frame.
  localparam logic [SW-1:0] SYNC_RST = {4'b0100, {N_CH{1'b0}}};
  localparam logic [4:0] FRAME_CNT = 5'(FRAME_BITS);
  localparam logic [4:0] CMD_CNT   = 5'(FRAME_BITS / 2);

  logic [SW-1:0]   sync_q [SYNC_STAGES];
  logic [SW-1:0]   sync_out;
  logic [N_CH-1:0] comp_s;
  logic            inj_s, sclk_s, cs_s, mosi_s;
  logic            inj_d, sclk_d, cs_d;
  logic            inj_rise, inj_fall, sclk_rise, sclk_fall, cs_rise;

  assign INJ_OUT = INJ_IN;

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {MOSI, CS_B, SCLK, INJ_IN, COMP};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];
  assign comp_s   = sync_out[N_CH-1:0];
  assign inj_s    = sync_out[N_CH];
  assign sclk_s   = sync_out[N_CH+1];
  assign cs_s     = sync_out[N_CH+2];
  assign mosi_s   = sync_out[N_CH+3];

  always_ff @(posedge CLK) begin
    if (RST) begin
      inj_d  <= 1'b0;
      sclk_d <= 1'b0;
      cs_d   <= 1'b1;
    end else begin
      inj_d  <= inj_s;
      sclk_d <= sclk_s;
      cs_d   <= cs_s;
    end
  end

  assign inj_rise  = inj_s & ~inj_d;
  assign inj_fall  = ~inj_s & inj_d;
  assign sclk_rise = sclk_s & ~sclk_d & ~cs_s;
  assign sclk_fall = ~sclk_s & sclk_d & ~cs_s;
  assign cs_rise   = cs_s & ~cs_d;

  chan_state_t     ch_state [N_CH];
  logic [N_CH-1:0] ovf;
  logic [N_CH-1:0] busy;
  logic [15:0]     tot_ext [N_CH];
`ifdef AFE_TOA_EN
  logic [15:0]     toa_ext [N_CH];
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic [TOT_WIDTH-1:0] tot;
`ifdef AFE_TOA_EN
    logic [TOT_WIDTH-1:0] toa;
`endif
    afe_tot_channel #(.TOT_WIDTH(TOT_WIDTH)) u_ch (
      .clk      (CLK),
      .rst      (RST),
      .inj      (inj_s),
      .inj_rise (inj_rise),
      .inj_fall (inj_fall),
      .comp     (comp_s[g]),
      .state    (ch_state[g]),
      .hit      (HIT[g]),
      .ovf      (ovf[g]),
      .tot      (tot)
`ifdef AFE_TOA_EN
      ,
      .toa      (toa)
`endif
    );
    assign tot_ext[g] = 16'(tot);
`ifdef AFE_TOA_EN
    assign toa_ext[g] = 16'(toa);
`endif
    assign busy[g] = is_busy(ch_state[g]);
  end

  assign LED = |HIT;

  logic [4:0] bit_cnt;
  logic [7:0] rx_sr, rx_next, cmd, tx_sr, rd_mux;
  logic [6:0] rd_addr;

  assign rx_next = {rx_sr[6:0], mosi_s};

  // Decoded from the command byte as it completes, so the snapshot lands on the 8th edge.
  always_comb begin
    rd_mux  = '0;
    rd_addr = rx_next[6:0];
    case (rd_addr)
      ADDR_GPIO: rd_mux = GPIO;
      ADDR_HIT:  rd_mux = 8'(HIT);
      ADDR_OVF:  rd_mux = 8'(ovf);
      ADDR_BUSY: rd_mux = 8'(busy);
      default:   ;
    endcase
    for (int c = 0; c < N_CH; c++) begin
      if (rd_addr == ADDR_TOT_LO + 7'(c)) rd_mux = tot_ext[c][7:0];
      if (rd_addr == ADDR_TOT_HI + 7'(c)) rd_mux = tot_ext[c][15:8];
`ifdef AFE_TOA_EN
      if (rd_addr == ADDR_TOA_LO + 7'(c)) rd_mux = toa_ext[c][7:0];
      if (rd_addr == ADDR_TOA_HI + 7'(c)) rd_mux = toa_ext[c][15:8];
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      bit_cnt <= '0;
      rx_sr   <= '0;
      cmd     <= '0;
      tx_sr   <= '0;
      MISO    <= 1'b0;
      GPIO    <= '0;
    end else if (cs_s) begin
      bit_cnt <= '0;
      MISO    <= 1'b0;
      if (cs_rise && bit_cnt == FRAME_CNT && cmd[CMD_WR_BIT] && cmd[6:0] == ADDR_GPIO)
        GPIO <= rx_sr;
    end else begin
      if (sclk_rise) begin
        rx_sr <= rx_next;
        if (bit_cnt != 5'h1F) bit_cnt <= bit_cnt + 5'd1;
        if (bit_cnt == CMD_CNT - 5'd1) begin
          cmd   <= rx_next;
          tx_sr <= rd_mux;
        end
      end
      if (sclk_fall) begin
        if (bit_cnt >= CMD_CNT && bit_cnt < FRAME_CNT) begin
          MISO  <= tx_sr[7];
          tx_sr <= {tx_sr[6:0], 1'b0};
        end else begin
          MISO <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_afe_tot_multi.sv
// Directed and randomized checks of afe_tot_multi through its pins and SPI port.
module tb_afe_tot_multi;

  localparam int N_CH        = 4;
  localparam int TOT_WIDTH   = 8;
  localparam int SYNC_STAGES = 2;
  localparam int H           = 8;   // SCLK half period in CLK cycles
  localparam int TOT_MAX     = (1 << TOT_WIDTH) - 1;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic            INJ_IN = 1'b0;
  logic [N_CH-1:0] COMP = '0;
  logic [N_CH-1:0] HIT;
  logic            INJ_OUT;
  logic            SCLK = 1'b0;
  logic            CS_B = 1'b1;
  logic            MOSI = 1'b0;
  logic            MISO;
  logic [7:0]      GPIO;
  logic            LED;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];

  afe_tot_multi #(
    .N_CH(N_CH), .TOT_WIDTH(TOT_WIDTH), .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .CLK(CLK), .RST(RST), .INJ_IN(INJ_IN), .COMP(COMP), .HIT(HIT),
    .INJ_OUT(INJ_OUT), .SCLK(SCLK), .CS_B(CS_B), .MOSI(MOSI), .MISO(MISO),
    .GPIO(GPIO), .LED(LED)
  );

  // clock / reset
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic spi_xfer(input logic [7:0] cmd, input logic [7:0] wdata, input int nbits,
                          input bit close, output logic [7:0] rdata);
    logic [15:0] frame;
    frame = {cmd, wdata};
    rdata = '0;
    tick(1);
    CS_B = 1'b0;
    tick(H);
    for (int i = 0; i < nbits; i++) begin
      MOSI = (i < 16) ? frame[15-i] : 1'b0;
      tick(H);
      if (i >= 8 && i < 16) rdata[15-i] = MISO;
      SCLK = 1'b1;
      tick(H);
      SCLK = 1'b0;
    end
    tick(H);
    if (close) begin
      CS_B = 1'b1;
      MOSI = 1'b0;
      tick(4 * H);
    end
  endtask

  task automatic spi_read(input logic [6:0] addr, output logic [7:0] data);
    spi_xfer({1'b0, addr}, 8'h00, 16, 1'b1, data);
  endtask

  task automatic spi_write(input logic [6:0] addr, input logic [7:0] data);
    logic [7:0] unused_rd;
    spi_xfer({1'b1, addr}, data, 16, 1'b1, unused_rd);
  endtask

  initial begin
    logic [7:0]      rd;
    logic [7:0]      all_ch;
    logic [7:0]      exp_toa;
    logic [N_CH-1:0] hit_mask;
    int s1[N_CH], l1[N_CH], s2[N_CH], l2[N_CH];
    bit has[N_CH], has2[N_CH];
    int max_end, e;

    all_ch = 8'((1 << N_CH) - 1);

    // Reset state
    RST = 1'b1;
    tick(4);
    check("rst_hit", 16'(HIT), 0);
    check("rst_gpio", 16'(GPIO), 0);
    check("rst_miso", 16'(MISO), 0);
    check("rst_led", 16'(LED), 0);
    INJ_IN = 1'b1;
    #1 check("inj_out_hi", 16'(INJ_OUT), 1);
    INJ_IN = 1'b0;
    #1 check("inj_out_lo", 16'(INJ_OUT), 0);
    tick(2);
    RST = 1'b0;
    tick(5);

    // 37-cycle pulse on channel 0 inside a 200-cycle injection
    INJ_IN = 1'b1;
    tick(20);
    COMP[0] = 1'b1;
    tick(SYNC_STAGES);
    check("t1_hit_early", 16'(HIT[0]), 0);
    tick(1);
    check("t1_hit_latency", 16'(HIT[0]), 1);
    tick(37 - SYNC_STAGES - 1);
    COMP[0] = 1'b0;
    tick(200 - 20 - 37);
    check("t1_hit_hold", 16'(HIT), 16'h1);
    check("t1_led", 16'(LED), 1);
    INJ_IN = 1'b0;
    tick(SYNC_STAGES + 2);
    check("t1_hit_clear", 16'(HIT), 0);
    check("t1_led_clear", 16'(LED), 0);
    spi_read(7'h10, rd);
    check("t1_tot0", 16'(rd), 16'h25);
    for (int c = 1; c < N_CH; c++) begin
      spi_read(7'h10 + 7'(c), rd);
      check("t1_tot_other", 16'(rd), 0);
    end
    spi_read(7'h20, rd);
    check("t1_tot0_hi", 16'(rd), 0);

    // New injection arriving mid-read must not disturb the snapshot
    fork
      spi_read(7'h10, rd);
      begin
        tick(23 * H);
        INJ_IN = 1'b1;
      end
    join
    check("snap_vs_inj", 16'(rd), 16'h25);
    tick(10);
    INJ_IN = 1'b0;
    tick(10);
    spi_read(7'h10, rd);
    check("reinj_clears_tot", 16'(rd), 0);

    // Long pulse on channel 1 saturates TOT
    INJ_IN = 1'b1;
    tick(10);
    COMP[1] = 1'b1;
    tick(400);
    COMP[1] = 1'b0;
    tick(10);
    spi_read(7'h01, rd);
    check("t2_hit_reg", 16'(rd), 16'h02);
    spi_read(7'h03, rd);
    check("t2_busy", 16'(rd), 16'(all_ch & ~8'h02));
    INJ_IN = 1'b0;
    tick(10);
    spi_read(7'h11, rd);
    check("t2_tot_sat", 16'(rd), 16'(TOT_MAX));
    spi_read(7'h02, rd);
    check("t2_ovf", 16'(rd), 16'h02);
    spi_read(7'h01, rd);
    check("t2_hit_after", 16'(rd), 0);
    spi_read(7'h03, rd);
    check("t2_busy_after", 16'(rd), 0);
    INJ_IN = 1'b1;
    tick(20);
    INJ_IN = 1'b0;
    tick(10);
    spi_read(7'h11, rd);
    check("t2_tot_reinj", 16'(rd), 0);
    spi_read(7'h02, rd);
    check("t2_ovf_reinj", 16'(rd), 0);

    // Only the first pulse of an injection is measured
    INJ_IN = 1'b1;
    tick(5);
    COMP[2] = 1'b1;
    tick(10);
    COMP[2] = 1'b0;
    tick(5);
    COMP[2] = 1'b1;
    tick(20);
    COMP[2] = 1'b0;
    tick(5);
    INJ_IN = 1'b0;
    tick(10);
    spi_read(7'h12, rd);
    check("t3_first_pulse", 16'(rd), 16'h0A);

    // Arrival time on channel 3
    INJ_IN = 1'b1;
    tick(15);
    COMP[3] = 1'b1;
    tick(10);
    COMP[3] = 1'b0;
    tick(5);
    INJ_IN = 1'b0;
    tick(10);
`ifdef AFE_TOA_EN
    exp_toa = 8'h0F;
`else
    exp_toa = 8'h00;
`endif
    spi_read(7'h33, rd);
    check("toa_lo", 16'(rd), 16'(exp_toa));
    spi_read(7'h43, rd);
    check("toa_hi", 16'(rd), 0);
    spi_read(7'h13, rd);
    check("toa_chan_tot", 16'(rd), 16'h0A);

    // SPI register access
    spi_write(7'h00, 8'hA5);
    check("gpio_write", 16'(GPIO), 16'hA5);
    spi_read(7'h00, rd);
    check("gpio_read", 16'(rd), 16'hA5);
    spi_xfer(8'h80, 8'h3C, 12, 1'b1, rd);
    check("gpio_short_frame", 16'(GPIO), 16'hA5);
    spi_xfer(8'h80, 8'h3C, 20, 1'b1, rd);
    check("gpio_long_frame", 16'(GPIO), 16'hA5);
    spi_write(7'h01, 8'h3C);
    check("gpio_ro_write", 16'(GPIO), 16'hA5);
    spi_read(7'h7F, rd);
    check("unmapped_7f", 16'(rd), 0);
    spi_read(7'h10 + 7'(N_CH), rd);
    check("unmapped_chan", 16'(rd), 0);
    spi_xfer(8'h00, 8'h00, 6, 1'b0, rd);
    check("miso_cmd_byte", 16'(MISO), 0);
    CS_B = 1'b1;
    tick(4 * H);
    check("miso_idle", 16'(MISO), 0);

    // Randomized injections against a pulse-length model
    for (int it = 0; it < 4; it++) begin
      max_end  = 0;
      hit_mask = '0;
      for (int c = 0; c < N_CH; c++) begin
        has[c]  = ($urandom_range(0, 3) != 0);
        s1[c]   = $urandom_range(3, 20);
        l1[c]   = $urandom_range(1, 40);
        has2[c] = ($urandom_range(0, 1) != 0);
        s2[c]   = s1[c] + l1[c] + $urandom_range(3, 10);
        l2[c]   = $urandom_range(1, 20);
        e = !has[c] ? 0 : (has2[c] ? s2[c] + l2[c] : s1[c] + l1[c]);
        if (e > max_end) max_end = e;
        hit_mask[c] = has[c];
        exp_q.push_back(has[c] ? 8'((l1[c] > TOT_MAX) ? TOT_MAX : l1[c]) : 8'h00);
      end
      INJ_IN = 1'b1;
      for (int t = 0; t < max_end + 12; t++) begin
        for (int c = 0; c < N_CH; c++)
          COMP[c] = has[c] && ((t >= s1[c] && t < s1[c] + l1[c]) ||
                               (has2[c] && t >= s2[c] && t < s2[c] + l2[c]));
        tick(1);
        if (t == max_end + 6) begin
          check("rnd_hit", 16'(HIT), 16'(hit_mask));
          check("rnd_led", 16'(LED), 16'(|hit_mask));
        end
      end
      INJ_IN = 1'b0;
      COMP   = '0;
      tick(8);
      check("rnd_hit_clear", 16'(HIT), 0);
      for (int c = 0; c < N_CH; c++) begin
        spi_read(7'h10 + 7'(c), rd);
        check("rnd_tot", 16'(rd), 16'(exp_q.pop_front()));
      end
      spi_read(7'h02, rd);
      check("rnd_ovf", 16'(rd), 0);
    end

    // Reset while counting and in the middle of a read frame
    INJ_IN = 1'b1;
    tick(5);
    COMP[0] = 1'b1;
    tick(10);
    check("rst_mid_hit", 16'(HIT[0]), 1);
    spi_xfer(8'h00, 8'h00, 10, 1'b0, rd);
    check("rst_mid_miso", 16'(MISO), 1);
    RST = 1'b1;
    tick(1);
    check("rst_mid_hit0", 16'(HIT), 0);
    check("rst_mid_gpio0", 16'(GPIO), 0);
    check("rst_mid_miso0", 16'(MISO), 0);
    check("rst_mid_led0", 16'(LED), 0);
    INJ_IN = 1'b0;
    COMP   = '0;
    CS_B   = 1'b1;
    SCLK   = 1'b0;
    MOSI   = 1'b0;
    tick(3);
    RST = 1'b0;
    tick(5);
    spi_read(7'h00, rd);
    check("post_rst_gpio_rd", 16'(rd), 0);
    spi_write(7'h00, 8'h5A);
    check("post_rst_gpio", 16'(GPIO), 16'h5A);
    spi_read(7'h00, rd);
    check("post_rst_gpio_rd2", 16'(rd), 16'h5A);

    // final report
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/afe_tot_multi.md
Name: afe_tot_multi

Overview:
- Multi-channel successor to the single-channel AFE time-over-threshold logic in the AFE CPLD.
- Measures TOT of N_CH comparator outputs, gated by a shared injection strobe, in CLK cycles.
- Latches per-channel hit and overflow flags.
- Exposes results and an 8-bit GPIO register through a register-addressed SPI slave sampled synchronously in the CLK domain.

Parameters:
- N_CH, 4: number of comparator channels, 1..8.
- TOT_WIDTH, 8: TOT counter width, 1..16.
- SYNC_STAGES, 2: synchroniser depth on all asynchronous inputs, ≥2.

Ports:
- CLK  in  1  system clock; sole clock of the block.
- RST  in  1  reset, synchronous, active-high.
- INJ_IN  in  1  injection gate, asynchronous.
- COMP  in  N_CH  comparator outputs, asynchronous.
- HIT  out  N_CH  per-channel hit flags.
- INJ_OUT  out  1  combinational copy of INJ_IN.
- SCLK  in  1  SPI clock, mode 0, at most CLK/4.
- CS_B  in  1  SPI chip select, active-low.
- MOSI  in  1  SPI data in, MSB first.
- MISO  out  1  SPI data out, MSB first.
- GPIO  out  8  GPIO register.
- LED  out  1  OR of all HIT bits.

Behaviour:
- Reset values: all outputs 0 except INJ_OUT; every channel FSM in IDLE; counters and flags cleared; any SPI frame in progress is aborted.
- Synchronisation: INJ_IN, COMP, SCLK, CS_B and MOSI each pass through SYNC_STAGES flops. Edges are detected on the synchronised signals.
- Channel FSM states: IDLE, ARMED, COUNT, DONE.
  - Synchronised INJ rising edge, from any state: go to ARMED; clear tot, HIT and ovf.
  - ARMED, COMP high (level): go to COUNT; tot=1; HIT=1.
  - ARMED, INJ low: go to DONE; tot=0; HIT=0.
  - COUNT, COMP high and INJ high: tot+1. At all-ones, tot holds and ovf=1.
  - COUNT, COMP low or INJ low: go to DONE; tot frozen.
  - DONE: further COMP pulses are ignored (one pulse per injection). Hold until next INJ rising edge.
  - HIT clears on synchronised INJ falling edge. tot and ovf persist until the next INJ rising edge.
  - INJ rising and COMP high in the same cycle: ARMED is taken first; counting starts the following cycle.
- HIT latency: SYNC_STAGES+1 CLK cycles after COMP rises.
- SPI frame:
  - Exactly 16 SCLK rising edges while CS_B is low.
  - Byte 0 is the command: bit7 = 1 write / 0 read; bits6:0 = address.
  - Byte 1 is write data (MOSI) or read data (MISO).
  - MOSI is sampled on the synchronised SCLK rising edge.
  - MISO updates on the synchronised SCLK falling edge. MISO is 0 while CS_B is high and during byte 0.
  - Read data is snapshotted after the 8th rising edge.
  - A write commits on the CS_B rising edge only if the bit count is exactly 16; otherwise it is discarded.
  - An INJ event during a frame does not corrupt the snapshot.
- Register map:
  - 0x00 GPIO, read/write.
  - 0x01 HIT flags, read-only, zero-extended.
  - 0x02 ovf flags, read-only.
  - 0x03 busy: bit c = 1 if channel c is in ARMED or COUNT.
  - 0x10+c: tot[7:0].
  - 0x20+c: tot[15:8], zero-extended.
  - Unmapped addresses, and c ≥ N_CH, read 0x00. Writes to them are ignored.
- Reads have no side effects.

Optional Feature:
- Macro AFE_TOA_EN.
- Defined: each channel adds a TOA counter of TOT_WIDTH bits.
  - Cleared on INJ rising edge; increments every cycle in ARMED; saturates at all-ones.
  - Frozen on entering COUNT or DONE.
  - Readable at 0x30+c (low byte) and 0x40+c (high byte).
- Undefined: no TOA logic is present; 0x30–0x4F read 0x00.

Decomposition:
- Package afe_pkg holds:
  - register address constants (ADDR_GPIO, ADDR_HIT, ADDR_OVF, ADDR_BUSY, ADDR_TOT_LO/HI base, ADDR_TOA_LO/HI base);
  - command write-bit index;
  - channel FSM state encoding;
  - SPI frame length constant (16).
- Sub-module afe_tot_channel holds one channel's FSM, tot counter, ovf and HIT (plus TOA under macro). It is instantiated N_CH times via generate.
- Synchronisers and the SPI shift/decode logic stay in the top level.

Test Plan:
- INJ high 200 cycles, COMP[0] high for 37 cycles from cycle 20 → HIT[0]=1 within SYNC_STAGES+1 cycles; read 0x10 returns 0x25; HIT[0] clears after INJ falls; the other channels read 0.
- TOT_WIDTH=8, COMP[1] high for 400 cycles inside INJ → 0x11 reads 0xFF; 0x02 bit1=1; re-injection clears both.
- Second COMP[2] pulse after a first 10-cycle pulse in the same injection → 0x12 reads 0x0A.
- SPI write 0x80,0xA5 → GPIO=0xA5, read 0x00 returns 0xA5. A 12-bit write frame leaves GPIO unchanged. Unmapped read 0x7F returns 0x00.
- RST asserted while in COUNT and mid-SPI-frame → next cycle: HIT=0, GPIO=0, MISO=0; the next full SPI frame operates normally.
- AFE_TOA_EN defined, COMP[3] rises 15 synchronised cycles after INJ → 0x33 reads 0x0F. Macro undefined → 0x33 reads 0x00.
